scope_plotter: RTL and testbench



---
 rtl/scope_pkg.sv | 32 +++
 rtl/scope_colmem.sv | 26 ++
 rtl/scope_plotter.sv | 222 ++++++++++++++++++++++
 tb/tb_scope_plotter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared constants, controller states and sample-to-row mapping for the scope plotter.
package scope_pkg;

    localparam int SCR_WIDTH  = 320;
    localparam int SCR_HEIGHT = 240;
    localparam int Y_CENTRE   = SCR_HEIGHT / 2;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        SEG,
        ERASE,
        DRAW,
        WRITE
    } state_t;

    // Row for a sample: centre minus the signed upper byte, clamped onto the screen.
    function automatic logic [7:0] map_y(input logic [15:0] smp, input int height);
        int s;
        int ny;
        s  = int'($signed(smp)) >>> 8;
        ny = height / 2 - s;
        if (ny < 0) begin
            ny = 0;
        end else if (ny > height - 1) begin
            ny = height - 1;
        end
        return 8'(ny);
    endfunction

endpackage

// File: rtl/scope_colmem.sv
// Per-column record of the last drawn trace segment, {min[7:0], max[7:0]}.
module scope_colmem #(
    parameter int DEPTH = 320,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scope_plotter.sv
// Scrolling oscilloscope trace: decimates the sample bus and writes one pixel per clock
// to the vga_adapter, erasing each column's old segment before drawing the new one.
module scope_plotter
    import scope_pkg::*;
#(
    parameter int WIDTH  = SCR_WIDTH,
    parameter int HEIGHT = SCR_HEIGHT,
    parameter int DECIM  = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] sample,
    input  logic        freeze,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        colour,
    output logic        plot,
    output logic        busy,
    output logic        overrun
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    state_t          state_q, state_d;
    logic [8:0]      col_q, col_d;
    logic [7:0]      row_q, row_d;
    logic [7:0]      prev_y_q, prev_y_d;
    logic [7:0]      ny_q, ny_d;
    logic [7:0]      old_max_q, old_max_d;
    logic [7:0]      new_min_q, new_min_d;
    logic [7:0]      new_max_q, new_max_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic            pending_q, pending_d;
    logic [15:0]     hold_q, hold_d;
    logic            overrun_q, overrun_d;
    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic            colour_q, colour_d;
    logic            plot_q, plot_d;

    logic            tick;
    logic            consume;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [15:0]     mem_wdata;
    logic [AW-1:0]   mem_raddr;
    logic [15:0]     mem_rdata;

    scope_colmem #(
        .DEPTH(WIDTH),
        .AW   (AW)
    ) u_colmem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        prev_y_d  = prev_y_q;
        ny_d      = ny_q;
        old_max_d = old_max_q;
        new_min_d = new_min_q;
        new_max_d = new_max_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = col_q[AW-1:0];
        mem_wdata = {new_min_q, new_max_q};
        mem_raddr = col_q[AW-1:0];

        tick    = (state_q != CLEAR) && (tick_q == CW'(DECIM - 1));
        consume = (state_q == IDLE) && pending_q;
        tick_d  = (state_q == CLEAR || tick) ? '0 : tick_q + CW'(1);

        if (consume) begin
            pending_d = 1'b0;
        end
        // A pending tick consumed this very cycle does not count as an overrun.
        if (tick && !freeze) begin
            hold_d    = sample;
            pending_d = 1'b1;
            if (pending_q && !consume) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            CLEAR: begin
                // col/row double as the raster counters; col ends back at 0.
                plot_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = 1'b0;
                if (row_q == '0) begin
                    mem_we    = 1'b1;
                    mem_wdata = {8'(HEIGHT / 2), 8'(HEIGHT / 2)};
                end
                if (col_q == 9'(WIDTH - 1)) begin
                    col_d = '0;
                    if (row_q == 8'(HEIGHT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 8'd1;
                    end
                end else begin
                    col_d = col_q + 9'd1;
                end
            end
            IDLE: begin
                if (pending_q) begin
                    state_d = READ;
                end
            end
            READ: begin
                ny_d    = map_y(hold_q, HEIGHT);
                state_d = SEG;
            end
            SEG: begin
                row_d     = mem_rdata[15:8];
                old_max_d = mem_rdata[7:0];
                if (col_q == '0) begin
                    new_min_d = ny_q;
                    new_max_d = ny_q;
                end else begin
                    new_min_d = (prev_y_q < ny_q) ? prev_y_q : ny_q;
                    new_max_d = (prev_y_q < ny_q) ? ny_q : prev_y_q;
                end
                state_d = ERASE;
            end
            ERASE: begin
                plot_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = 1'b0;
                if (row_q == old_max_q) begin
                    row_d   = new_min_q;
                    state_d = DRAW;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end
            DRAW: begin
                plot_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = 1'b1;
                if (row_q == new_max_q) begin
                    state_d = WRITE;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                prev_y_d = ny_q;
                col_d    = (col_q == 9'(WIDTH - 1)) ? '0 : col_q + 9'd1;
                state_d  = IDLE;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= CLEAR;
            col_q     <= '0;
            row_q     <= '0;
            prev_y_q  <= 8'(HEIGHT / 2);
            ny_q      <= '0;
            old_max_q <= '0;
            new_min_q <= '0;
            new_max_q <= '0;
            tick_q    <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= 1'b0;
            plot_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            prev_y_q  <= prev_y_d;
            ny_q      <= ny_d;
            old_max_q <= old_max_d;
            new_min_q <= new_min_d;
            new_max_q <= new_max_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_scope_plotter.sv
// Directed bench: full-size plotter for clear/trace/freeze, narrow ones for wrap and overrun.
module tb_scope_plotter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, rst_o;
    logic [15:0] smp_m, smp_w, smp_o;
    logic        frz_m;
    logic [8:0]  x_m, x_w, x_o;
    logic [7:0]  y_m, y_w, y_o;
    logic        c_m, c_w, c_o, p_m, p_w, p_o, b_m, b_w, b_o, o_m, o_w, o_o;

    scope_plotter #(.DECIM(600)) u_main (
        .clk(clk), .resetn(resetn), .sample(smp_m), .freeze(frz_m),
        .x(x_m), .y(y_m), .colour(c_m), .plot(p_m), .busy(b_m), .overrun(o_m)
    );

    scope_plotter #(.WIDTH(8), .DECIM(600)) u_wrap (
        .clk(clk), .resetn(resetn), .sample(smp_w), .freeze(1'b0),
        .x(x_w), .y(y_w), .colour(c_w), .plot(p_w), .busy(b_w), .overrun(o_w)
    );

    scope_plotter #(.WIDTH(8), .DECIM(16)) u_ovr (
        .clk(clk), .resetn(rst_o), .sample(smp_o), .freeze(1'b0),
        .x(x_o), .y(y_o), .colour(c_o), .plot(p_o), .busy(b_o), .overrun(o_o)
    );

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       c;
    } px_t;

    px_t q_m[$];
    px_t q_w[$];
    int  oob_m = 0;
    int  oob_o = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  done_w = 1'b0;
    bit  done_o = 1'b0;

    always @(negedge clk) begin
        if (p_m === 1'b1) begin
            q_m.push_back({x_m, y_m, c_m});
            if (y_m > 8'd239) oob_m++;
        end
        if (p_w === 1'b1) q_w.push_back({x_w, y_w, c_w});
        if (p_o === 1'b1 && (y_o > 8'd239 || x_o > 9'd7 || c_o === 1'bx)) oob_o++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic busy_of(input int which);
        case (which)
            0:       return b_m;
            1:       return b_w;
            default: return b_o;
        endcase
    endfunction

    task automatic wait_busy(input int which, input logic level, input int limit, input string tag);
        int n;
        n = 0;
        while (busy_of(which) !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy_of(which)), 32'(level));
    endtask

    task automatic wait_col(input int which, input string tag);
        wait_busy(which, 1'b1, 1400, {tag, "_start"});
        wait_busy(which, 1'b0, 600, {tag, "_end"});
        @(negedge clk);
    endtask

    // Compare the captured pixels of one column against erase-then-draw ascending runs.
    task automatic check_col(input int which, input string tag, input int xc,
                             input int omin, input int omax, input int nmin, input int nmax);
        px_t got[$];
        px_t exp_q[$];
        int  bad;
        if (which == 0) got = q_m; else got = q_w;
        for (int yy = omin; yy <= omax; yy++) exp_q.push_back({9'(xc), 8'(yy), 1'b0});
        for (int yy = nmin; yy <= nmax; yy++) exp_q.push_back({9'(xc), 8'(yy), 1'b1});
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) bad++;
        end
        check({tag, "_px_bad"}, 32'(bad), 32'd0);
        if (which == 0) q_m.delete(); else q_w.delete();
    endtask

    // Full-size instance: reset, clear raster, trace columns, clamping, freeze.
    initial begin
        int bad;
        int n;
        resetn = 1'b0;
        smp_m  = 16'h0000;
        frz_m  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x_m), 0);
        check("rst_y", 32'(y_m), 0);
        check("rst_colour", 32'(c_m), 0);
        check("rst_plot", 32'(p_m), 0);
        check("rst_busy", 32'(b_m), 1);
        check("rst_overrun", 32'(o_m), 0);
        resetn = 1'b1;

        bad = 0;
        for (int i = 0; i < 76800; i++) begin
            @(negedge clk);
            if (!(p_m === 1'b1 && c_m === 1'b0 && x_m === 9'(i % 320) && y_m === 8'(i / 320))) bad++;
        end
        check("clear_raster_bad", 32'(bad), 0);
        @(negedge clk);
        check("clear_plot_after", 32'(p_m), 0);
        check("clear_busy_after", 32'(b_m), 0);
        q_m.delete();

        wait_col(0, "c0"); check_col(0, "c0", 0, 120, 120, 120, 120);
        wait_col(0, "c1"); check_col(0, "c1", 1, 120, 120, 120, 120);
        smp_m = 16'h7FFF;
        wait_col(0, "c2_clamp_top"); check_col(0, "c2_clamp_top", 2, 120, 120, 0, 120);
        smp_m = 16'h8000;
        wait_col(0, "c3_clamp_bot"); check_col(0, "c3_clamp_bot", 3, 120, 120, 0, 239);
        smp_m = 16'h0000;
        wait_col(0, "c4"); check_col(0, "c4", 4, 120, 120, 120, 239);
        smp_m = 16'h1400;
        wait_col(0, "c5_s20"); check_col(0, "c5_s20", 5, 120, 120, 100, 120);
        smp_m = 16'h8000;

        wait_busy(0, 1'b1, 1400, "c6_start");
        n = 0;
        while (!(p_m === 1'b1 && c_m === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("c6_draw_seen", 32'(p_m & c_m), 1);
        frz_m = 1'b1;
        wait_busy(0, 1'b0, 600, "c6_end");
        @(negedge clk);
        check_col(0, "c6_freeze", 6, 120, 120, 100, 239);
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (p_m !== 1'b0 || b_m !== 1'b0) bad++;
        end
        check("freeze_quiet", 32'(bad), 0);
        frz_m = 1'b0;
        smp_m = 16'h0000;
        wait_col(0, "c7_resume"); check_col(0, "c7_resume", 7, 120, 120, 120, 239);

        check("main_y_range", 32'(oob_m), 0);
        check("main_overrun", 32'(o_m), 0);

        n = 0;
        while (!(done_w && done_o) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("aux_done", 32'(done_w && done_o), 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Narrow instance: column index wraps after WIDTH-1 with no connecting line.
    initial begin
        smp_w = 16'h1400;
        wait (resetn === 1'b1);
        wait_busy(1, 1'b0, 3000, "w_clear");
        @(negedge clk);
        q_w.delete();
        wait_col(1, "w0"); check_col(1, "w0", 0, 120, 120, 100, 100);
        smp_w = 16'h0000;
        wait_col(1, "w1"); check_col(1, "w1", 1, 120, 120, 100, 120);
        for (int k = 2; k < 8; k++) begin
            wait_col(1, $sformatf("w%0d", k));
            check_col(1, $sformatf("w%0d", k), k, 120, 120, 120, 120);
        end
        smp_w = 16'h8000;
        wait_col(1, "w_wrap"); check_col(1, "w_wrap", 0, 100, 100, 239, 239);
        done_w = 1'b1;
    end

    // Fast-tick instance: long segments overlap ticks, overrun sticks until reset.
    initial begin
        rst_o = 1'b0;
        smp_o = 16'h7F00;
        repeat (3) @(negedge clk);
        check("ovr_rst", 32'(o_o), 0);
        rst_o = 1'b1;
        wait_busy(2, 1'b0, 3000, "o_clear");
        check("ovr_after_clear", 32'(o_o), 0);
        for (int i = 0; i < 100; i++) begin
            repeat (16) @(negedge clk);
            smp_o = (smp_o == 16'h7F00) ? 16'h8000 : 16'h7F00;
        end
        check("ovr_set", 32'(o_o), 1);
        smp_o = 16'h0000;
        repeat (500) @(negedge clk);
        check("ovr_sticky", 32'(o_o), 1);
        check("ovr_range", 32'(oob_o), 0);
        rst_o = 1'b0;
        @(negedge clk);
        check("ovr_cleared", 32'(o_o), 0);
        check("ovr_rst_busy", 32'(b_o), 1);
        done_o = 1'b1;
    end

endmodule
